// File: rtl/madcap_pkg.sv
// rtl/madcap_pkg.sv - shared types and constants for the transmit dispatch path
package madcap_pkg;

    localparam int MADCAP_WIDTH = 64;

    typedef enum logic [2:0] {
        DS_IDLE      = 3'd0,
        DS_LOAD      = 3'd1,
        DS_HOLD      = 3'd2,
        DS_WAIT_BUSY = 3'd3,
        DS_WAIT_IDLE = 3'd4
    } dispatch_state_t;

endpackage

// File: rtl/tx_dispatch_fifo_if.sv
// rtl/tx_dispatch_fifo_if.sv - writer and hydra_ctrl load-port signals of the dispatcher
interface tx_dispatch_fifo_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-2:0] rx_data;
    logic             rx_data_flag;
    logic [WIDTH-2:0] local_data;
    logic             local_wr_req;
    logic             local_wr_ack;
    logic             tx_busy_any;
    logic [WIDTH-2:0] fifo_data;
    logic             ld_tx_data;
    logic             comms_busy;

    modport master (
        output rx_data, rx_data_flag, local_data, local_wr_req, tx_busy_any,
        input  local_wr_ack, fifo_data, ld_tx_data, comms_busy
    );

    modport slave (
        input  rx_data, rx_data_flag, local_data, local_wr_req, tx_busy_any,
        output local_wr_ack, fifo_data, ld_tx_data, comms_busy
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO storage with pointers, word counter and flags
module sync_fifo #(
    parameter int DW    = 63,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    input  logic                   rd_en,
    output logic [DW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;

    // Callers guarantee wr_en only when not full and rd_en only when not empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;
    assign empty      = empty_q;
    assign full       = full_q;

endmodule

// File: rtl/tx_dispatch_fifo.sv
// rtl/tx_dispatch_fifo.sv - merges rx and local packets into a FIFO and paces loads into hydra_ctrl
module tx_dispatch_fifo
    import madcap_pkg::*;
#(
    parameter int WIDTH        = MADCAP_WIDTH,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    tx_dispatch_fifo_if.slave      bus,
    input  logic                   clear_overflow,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_counter,
    output logic                   fifo_overflow,
    output logic                   tx_timeout
);
    localparam int DW = WIDTH - 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    dispatch_state_t state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [DW-1:0]   fifo_data_q, fifo_data_d;
    logic            ld_tx_data_q, ld_tx_data_d;
    logic            tx_timeout_q, tx_timeout_d;
    logic            comms_busy_q, comms_busy_d;
    logic            overflow_q, overflow_d;

    logic            local_ack;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            pop;
    logic [DW-1:0]   head_data;
    logic [CW-1:0]   count_next;

    // rx has priority; the local writer simply waits, so only rx words can be lost.
    always_comb begin
        local_ack = bus.local_wr_req & ~bus.rx_data_flag & ~fifo_full;
        wr_en     = (bus.rx_data_flag & ~fifo_full) | local_ack;
        wr_data   = bus.rx_data_flag ? bus.rx_data : bus.local_data;
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop),
        .rd_data    (head_data),
        .count      (fifo_counter),
        .count_next (count_next),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (bus.rx_data_flag & fifo_full) begin
            overflow_d = 1'b1;
        end
        comms_busy_d = (count_next >= CW'(DEPTH - 1));
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        fifo_data_d  = fifo_data_q;
        tx_timeout_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (!fifo_empty && !bus.tx_busy_any) begin
                    state_d     = DS_LOAD;
                    pop         = 1'b1;
                    fifo_data_d = head_data;
                end
            end
            DS_LOAD: state_d = DS_HOLD;
            DS_HOLD: begin
                state_d = DS_WAIT_BUSY;
                timer_d = '0;
            end
            DS_WAIT_BUSY: begin
                if (bus.tx_busy_any) begin
                    state_d = DS_WAIT_IDLE;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    // No UART picked the word up (e.g. every TX port disabled).
                    state_d      = DS_IDLE;
                    tx_timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DS_WAIT_IDLE: begin
                if (!bus.tx_busy_any) begin
                    state_d = DS_IDLE;
                end
            end
            default: state_d = DS_IDLE;
        endcase
        ld_tx_data_d = (state_d == DS_LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DS_IDLE;
            timer_q      <= '0;
            fifo_data_q  <= '0;
            ld_tx_data_q <= 1'b0;
            tx_timeout_q <= 1'b0;
            comms_busy_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fifo_data_q  <= fifo_data_d;
            ld_tx_data_q <= ld_tx_data_d;
            tx_timeout_q <= tx_timeout_d;
            comms_busy_q <= comms_busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.local_wr_ack = local_ack;
    assign bus.fifo_data    = fifo_data_q;
    assign bus.ld_tx_data   = ld_tx_data_q;
    assign bus.comms_busy   = comms_busy_q;
    assign fifo_overflow    = overflow_q;
    assign tx_timeout       = tx_timeout_q;

endmodule

// File: tb/tb_tx_dispatch_fifo.sv
// tb/tb_tx_dispatch_fifo.sv - scoreboard bench for tx_dispatch_fifo
module tb_tx_dispatch_fifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int BT    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_overflow;
    logic        fifo_empty, fifo_full, fifo_overflow, tx_timeout;
    logic [4:0]  fifo_counter;
    logic        busy_force;
    logic        busy_model = 1'b0;

    tx_dispatch_fifo_if #(.WIDTH(WIDTH)) bus ();
    assign bus.tx_busy_any = busy_force | busy_model;

    tx_dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus.slave),
        .clear_overflow (clear_overflow),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_counter   (fifo_counter),
        .fifo_overflow  (fifo_overflow),
        .tx_timeout     (tx_timeout)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ld_count = 0;
    int          last_ld_cyc = 0;
    int          busy_cnt = 0;
    bit          hydra_en = 1'b1;
    bit          prev_ld = 1'b0;
    logic [62:0] prev_data = '0;
    logic [62:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Load monitor: pops the scoreboard on every strobe and models hydra_ctrl's busy.
    always @(negedge clk) begin
        logic [62:0] exp_w;
        if (prev_ld) begin
            checks++;
            if (bus.fifo_data !== prev_data) begin
                failures++;
                $display("FAIL hold_stable got=%h exp=%h", bus.fifo_data, prev_data);
            end
        end
        prev_ld   = bus.ld_tx_data;
        prev_data = bus.fifo_data;
        if (bus.ld_tx_data) begin
            ld_count++;
            last_ld_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_load data=%h", bus.fifo_data);
            end else begin
                exp_w = sb.pop_front();
                if (bus.fifo_data !== exp_w) begin
                    failures++;
                    $display("FAIL load_data got=%h exp=%h", bus.fifo_data, exp_w);
                end
            end
        end
        if (bus.ld_tx_data && hydra_en) begin
            busy_model = 1'b1;
            busy_cnt   = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) busy_model = 1'b0;
        end
    end

    task automatic push_local(input logic [62:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.local_wr_req = 1'b1;
        bus.local_data   = d;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.local_wr_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL local_ack_timeout got=0 exp=1");
        end else begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1 bus.local_wr_req = 1'b0;
    endtask

    task automatic rx_write(input logic [62:0] d);
        @(negedge clk);
        bus.rx_data_flag = 1'b1;
        bus.rx_data      = d;
        @(posedge clk);
        #1 bus.rx_data_flag = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && fifo_empty) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", sb.size());
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (bus.fifo_data !== '0 || bus.ld_tx_data !== 1'b0 || bus.comms_busy !== 1'b0 ||
            fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_counter !== 5'd0 ||
            fifo_overflow !== 1'b0 || tx_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s got data=%h ld=%b cb=%b e=%b f=%b cnt=%0d ov=%b to=%b exp all reset values",
                     tag, bus.fifo_data, bus.ld_tx_data, bus.comms_busy, fifo_empty, fifo_full,
                     fifo_counter, fifo_overflow, tx_timeout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.local_wr_req = 1'b1;
        bus.local_data   = 63'h1234;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        #1;
        checks++;
        if (bus.local_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL reset_ack got=%b exp=1", bus.local_wr_ack);
        end
        bus.local_wr_req = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        push_local(63'h7FFF_0000_0000_0001);
        @(negedge clk);
        checks++;
        if (fifo_counter !== 5'd1 || bus.ld_tx_data !== 1'b0) begin
            failures++;
            $display("FAIL single_after_write got cnt=%0d ld=%b exp cnt=1 ld=0", fifo_counter, bus.ld_tx_data);
        end
        @(negedge clk);
        checks++;
        if (bus.ld_tx_data !== 1'b1 || fifo_counter !== 5'd0) begin
            failures++;
            $display("FAIL single_latency got ld=%b cnt=%0d exp ld=1 cnt=0", bus.ld_tx_data, fifo_counter);
        end
        drain();
    endtask

    task automatic test_collision();
        @(negedge clk);
        bus.rx_data_flag = 1'b1;
        bus.rx_data      = 63'h0AAA_AAAA_AAAA_AAAA;
        bus.local_wr_req = 1'b1;
        bus.local_data   = 63'h0555_5555_5555_5555;
        #1;
        checks++;
        if (bus.local_wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL collision_ack_blocked got=%b exp=0", bus.local_wr_ack);
        end
        sb.push_back(63'h0AAA_AAAA_AAAA_AAAA);
        @(posedge clk);
        #1 bus.rx_data_flag = 1'b0;
        #1;
        checks++;
        if (bus.local_wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL collision_ack_next got=%b exp=1", bus.local_wr_ack);
        end
        sb.push_back(63'h0555_5555_5555_5555);
        @(posedge clk);
        #1 bus.local_wr_req = 1'b0;
        drain();
    endtask

    task automatic test_overflow();
        logic [4:0] exp_cnt;
        busy_force = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            rx_write(63'(64'h100 + k));
            if (k <= 16) sb.push_back(63'(64'h100 + k));
            exp_cnt = (k > 16) ? 5'd16 : 5'(k);
            checks++;
            if (fifo_counter !== exp_cnt || fifo_full !== (k >= 16) ||
                bus.comms_busy !== (k >= 15) || fifo_overflow !== (k >= 17)) begin
                failures++;
                $display("FAIL fill_%0d got cnt=%0d full=%b cb=%b ov=%b exp cnt=%0d full=%b cb=%b ov=%b",
                         k, fifo_counter, fifo_full, bus.comms_busy, fifo_overflow,
                         exp_cnt, (k >= 16), (k >= 15), (k >= 17));
            end
        end
        @(negedge clk);
        bus.local_wr_req = 1'b1;
        bus.local_data   = 63'h7;
        #1;
        checks++;
        if (bus.local_wr_ack !== 1'b0) begin
            failures++;
            $display("FAIL full_local_ack got=%b exp=0", bus.local_wr_ack);
        end
        @(posedge clk);
        #1 bus.local_wr_req = 1'b0;
        @(negedge clk);
        bus.rx_data_flag = 1'b1;
        clear_overflow   = 1'b1;
        @(posedge clk);
        #1 bus.rx_data_flag = 1'b0;
        clear_overflow = 1'b0;
        checks++;
        if (fifo_overflow !== 1'b1 || fifo_counter !== 5'd16) begin
            failures++;
            $display("FAIL set_beats_clear got ov=%b cnt=%0d exp ov=1 cnt=16", fifo_overflow, fifo_counter);
        end
        @(negedge clk);
        clear_overflow = 1'b1;
        @(posedge clk);
        #1 clear_overflow = 1'b0;
        checks++;
        if (fifo_overflow !== 1'b0) begin
            failures++;
            $display("FAIL clear_overflow got=%b exp=0", fifo_overflow);
        end
        @(negedge clk);
        busy_force       = 1'b0;
        bus.rx_data_flag = 1'b1;
        bus.rx_data      = 63'h0DEAD;
        @(posedge clk);
        #1 bus.rx_data_flag = 1'b0;
        checks++;
        if (fifo_overflow !== 1'b1 || fifo_counter !== 5'd15 || fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL pop_no_rescue got ov=%b cnt=%0d full=%b exp ov=1 cnt=15 full=0",
                     fifo_overflow, fifo_counter, fifo_full);
        end
        drain();
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
    endtask

    task automatic test_timeout();
        bit seen;
        int first_ld;
        hydra_en = 1'b0;
        seen = 1'b0;
        push_local(63'h0000_1111);
        push_local(63'h0000_2222);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_timeout === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        first_ld = last_ld_cyc;
        checks++;
        if (!seen || (cyc - first_ld) != BT + 2) begin
            failures++;
            $display("FAIL timeout_distance got seen=%b dist=%0d exp seen=1 dist=%0d", seen, cyc - first_ld, BT + 2);
        end
        @(negedge clk);
        checks++;
        if (bus.ld_tx_data !== 1'b1 || tx_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next_load got ld=%b to=%b exp ld=1 to=0", bus.ld_tx_data, tx_timeout);
        end
        drain();
        repeat (BT) @(negedge clk);
        hydra_en = 1'b1;
    endtask

    task automatic test_stream();
        int start_ld;
        start_ld = ld_count;
        for (int n = 0; n < 40; n++) begin
            push_local({31'($urandom), 32'($urandom)});
        end
        drain();
        checks++;
        if (fifo_counter !== 5'd0 || fifo_empty !== 1'b1 || (ld_count - start_ld) != 40) begin
            failures++;
            $display("FAIL stream_end got cnt=%0d empty=%b loads=%0d exp cnt=0 empty=1 loads=40",
                     fifo_counter, fifo_empty, ld_count - start_ld);
        end
    endtask

    task automatic test_reset_mid();
        int start_ld;
        bit seen;
        hydra_en = 1'b0;
        seen = 1'b0;
        start_ld = ld_count;
        for (int n = 0; n < 4; n++) push_local(63'(64'hC0 + n));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ld_count != start_ld) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!seen || fifo_counter !== 5'd3) begin
            failures++;
            $display("FAIL reset_mid_setup got seen=%b cnt=%0d exp seen=1 cnt=3", seen, fifo_counter);
        end
        #2 reset = 1'b1;
        #1;
        check_reset_values("reset_mid_values");
        sb.delete();
        start_ld = ld_count;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (ld_count != start_ld || fifo_empty !== 1'b1 || fifo_counter !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_after got loads=%0d empty=%b cnt=%0d exp loads=0 empty=1 cnt=0",
                     ld_count - start_ld, fifo_empty, fifo_counter);
        end
        hydra_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        clear_overflow   = 1'b0;
        busy_force       = 1'b0;
        bus.rx_data      = '0;
        bus.rx_data_flag = 1'b0;
        bus.local_data   = '0;
        bus.local_wr_req = 1'b0;
        test_reset();
        test_single();
        test_collision();
        test_overflow();
        test_timeout();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_dispatch_fifo.md
# tx_dispatch_fifo

Event buffer and transmit dispatcher in front of `hydra_ctrl`. It merges 63-bit packets from two writers into a synchronous FIFO: received packets from `hydra_ctrl` (`rx_data`/`rx_data_flag`) and locally generated packets from the digital core. It then pops packets one at a time into `hydra_ctrl`'s `fifo_data`/`ld_tx_data` load port. A new load waits until the previous UART transmit has finished.

## Interface
- `WIDTH`, 64, packet width including start/stop framing; the data path is `WIDTH-1` bits.
- `DEPTH`, 16, FIFO depth in words; must be a power of two, minimum 4.
- `BUSY_TIMEOUT`, 32, cycles to wait for `tx_busy_any` to rise after a load.
- `clk`  in  1  master clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  WIDTH-1  received packet from `hydra_ctrl`.
- `rx_data_flag`  in  1  one-cycle pulse: `rx_data` valid.
- `local_data`  in  WIDTH-1  locally generated packet.
- `local_wr_req`  in  1  local writer request; held high until acknowledged.
- `local_wr_ack`  out  1  combinational acknowledge: local word written at this edge.
- `tx_busy_any`  in  1  any transmit UART busy.
- `clear_overflow`  in  1  clears `fifo_overflow`.
- `fifo_data`  out  WIDTH-1  packet presented to `hydra_ctrl`.
- `ld_tx_data`  out  1  one-cycle load strobe to `hydra_ctrl`.
- `comms_busy`  out  1  back-pressure to the `hydra_ctrl` RX path.
- `fifo_empty`, `fifo_full`  out  1 each  FIFO status.
- `fifo_counter`  out  $clog2(DEPTH)+1  words held.
- `fifo_overflow`  out  1  sticky: a write was dropped.
- `tx_timeout`  out  1  one-cycle pulse: busy never rose after a load.

## Operation
- Write arbitration, one write per cycle:
  - `rx_data_flag` has priority over the local writer.
  - `local_wr_ack = local_wr_req & !rx_data_flag & !fifo_full`.
- Write while full: dropped and `fifo_overflow` set.
  - A pop in the same cycle does not rescue the write.
  - `local_wr_ack` stays low while full, so local words are never dropped.
- `fifo_overflow` clears on `clear_overflow`. A set and a clear in the same cycle resolve to set.
- `comms_busy` is registered and high when `fifo_counter >= DEPTH-1`.
- Dispatch FSM states: IDLE, LOAD, HOLD, WAIT_BUSY, WAIT_IDLE.
  - IDLE -> LOAD when `!fifo_empty & !tx_busy_any`. On that edge the head word is registered into `fifo_data` and the read pointer advances.
  - LOAD: `ld_tx_data = 1`. Always -> HOLD.
  - HOLD: `fifo_data` is held stable for `hydra_ctrl`'s second sample. Always -> WAIT_BUSY; the timer clears.
  - WAIT_BUSY: if `tx_busy_any` -> WAIT_IDLE. Else if timer == BUSY_TIMEOUT-1 -> IDLE and pulse `tx_timeout` (covers the case where no transmit port is enabled). Else the timer increments.
  - WAIT_IDLE -> IDLE when `!tx_busy_any`.
- `fifo_data` changes only on entry to LOAD. It holds its value otherwise, including while empty.
- `fifo_counter` is updated by +1 on write, -1 on pop, and is unchanged when both happen in the same cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing
- Reset values: `fifo_data = 0`, `ld_tx_data = 0`, `comms_busy = 0`, `fifo_empty = 1`, `fifo_full = 0`, `fifo_counter = 0`, `fifo_overflow = 0`, `tx_timeout = 0`, FSM in IDLE, pointers 0. `local_wr_ack` follows its equation with `fifo_full = 0`.
- Reset mid-transfer: the FIFO contents are discarded and `ld_tx_data` drops immediately.
- Latency: a word written at edge t into an empty FIFO, with `tx_busy_any` low, gives `ld_tx_data` high in the cycle after edge t+1.
- Minimum spacing between consecutive `ld_tx_data` pulses is 5 cycles: LOAD, HOLD, one cycle of WAIT_BUSY, WAIT_IDLE, IDLE.
- All outputs except `local_wr_ack` are registered.

## Structure
- Shared package `madcap_pkg`: dispatch state enum `dispatch_state_t` and the default `WIDTH` constant.
- Sub-module `sync_fifo`: storage, pointers, counter and full/empty flags. Arbitration and the FSM live in the top level.

## Test plan
- Single local write of 0x7FFF_0000_0000_0001 with `tx_busy_any` low -> `local_wr_ack` for 1 cycle; `ld_tx_data` 2 cycles later with that `fifo_data`, stable for 2 cycles.
- `rx_data_flag` and `local_wr_req` in the same cycle -> rx word written first; ack follows next cycle; dispatch order is rx then local.
- 17 rx writes with dispatch blocked (`tx_busy_any` held high) -> `fifo_full` after 16; 17th dropped; `fifo_overflow` = 1; `comms_busy` high from count 15.
- Load with `tx_busy_any` never rising -> `tx_timeout` pulses exactly BUSY_TIMEOUT cycles after HOLD; next word loads 1 cycle later.
- 40 words streamed through with pointer wrap -> output order matches input order; `fifo_counter` returns to 0 and `fifo_empty` = 1.
- Reset asserted during WAIT_BUSY with 3 words queued -> all outputs at reset values; no `ld_tx_data` after release.
